// File: rtl/ram_pkg.sv
// Shared definitions for ram_sync_param: FSM state encoding, default geometry
// and the even-parity helper used by both the RTL and its bench.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DEPTH  = 128;

    // Widest word the parity helper covers; zero-extension does not change XOR.
    localparam int PARITY_MAX_W = 64;

    function automatic logic parity(input logic [PARITY_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Storage for ram_sync_param: one write port and one synchronous read port.
// Holds no control logic; the caller guarantees addresses are below DEPTH.
module ram_array #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array and its read register carry no reset so they map onto
    // block RAM; the top zeroes contents with its clear sweep instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_sync_param.sv
// Parametrised single-port synchronous RAM with dual chip select, clear sweep,
// registered read with rd_valid and error pulses. Optional macro: RAM_PARITY_EN.
module ram_sync_param
    import ram_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs1,
    input  logic              cs2,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
`ifdef RAM_PARITY_EN
    input  logic              perr_inject,
    output logic              rd_perr,
`endif
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              ready,
    output logic              err
);

`ifdef RAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C    = (ADDR_W+1)'(DEPTH - 1);
    localparam state_t          RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    state_t              state, state_nxt;
    logic [ADDR_W:0]     clr_cnt, clr_cnt_nxt;
    logic                clr_we;

    logic                sel, in_range, req_ok, acc_rd, acc_wr, bad_req;
    logic                arr_we, arr_re;
    logic [ADDR_W-1:0]   arr_waddr;
    logic [WORD_W-1:0]   arr_wdata, arr_q, wr_word;
    logic                rd_zero;

    // Request decode; the extra counter/compare bit keeps DEPTH = 2**ADDR_W exact.
    assign sel      = cs1 & ~cs2;
    assign ready    = (state == ST_IDLE);
    assign in_range = ({1'b0, addr} < DEPTH_C);
    assign req_ok   = ready & sel & (rd ^ wr);
    assign acc_rd   = req_ok & rd;
    assign acc_wr   = req_ok & wr;
    assign bad_req  = ready & sel & ((rd & wr) | ((rd ^ wr) & ~in_range));

`ifdef RAM_PARITY_EN
    assign wr_word = {parity(PARITY_MAX_W'(wr_data)) ^ perr_inject, wr_data};
`else
    assign wr_word = wr_data;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_we      = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we      = 1'b1;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == LAST_C) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // The clear sweep owns the write port; bus traffic is ignored meanwhile.
    assign arr_we    = clr_we | (acc_wr & in_range);
    assign arr_waddr = clr_we ? clr_cnt[ADDR_W-1:0] : addr;
    assign arr_wdata = clr_we ? '0 : wr_word;
    assign arr_re    = acc_rd & in_range;

    ram_array #(
        .WIDTH  (WORD_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (arr_re),
        .raddr (addr),
        .rdata (arr_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RST_STATE;
            clr_cnt  <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
            rd_zero  <= 1'b1;
        end else begin
            state    <= state_nxt;
            clr_cnt  <= clr_cnt_nxt;
            rd_valid <= acc_rd;
            err      <= bad_req;
            if (acc_rd) begin
                rd_zero <= ~in_range;
            end
        end
    end

    // rd_zero masks the unreset array register: zero after reset and for
    // out-of-range reads, otherwise the word captured at the accepting edge.
    assign rd_data = rd_zero ? '0 : arr_q[DATA_W-1:0];

`ifdef RAM_PARITY_EN
    assign rd_perr = ~rd_zero & (arr_q[DATA_W] != parity(PARITY_MAX_W'(arr_q[DATA_W-1:0])));
`endif

endmodule

// File: tb/tb_ram_sync_param.sv
// Self-checking bench for ram_sync_param: a default instance plus a DEPTH=100
// instance sharing the bus; read data is checked through an expectation queue.
module tb_ram_sync_param;
    import ram_pkg::*;

    localparam int DW      = 8;
    localparam int AW      = 7;
    localparam int DEPTH_A = 128;
    localparam int DEPTH_B = 100;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          perr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cs1 = 1'b0, cs2 = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data, b_rd_data;
    logic          rd_valid, ready, err;
    logic          b_rd_valid, b_ready, b_err;
`ifdef RAM_PARITY_EN
    logic          perr_inject = 1'b0;
    logic          rd_perr, b_rd_perr;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] model      [DEPTH_A];
    logic          model_perr [DEPTH_A];
    exp_t          exp_q [$];

    always #5 clk = ~clk;

    ram_sync_param dut_a (
        .clk         (clk),
        .rst         (rst),
        .cs1         (cs1),
        .cs2         (cs2),
        .rd          (rd),
        .wr          (wr),
        .addr        (addr),
        .wr_data     (wr_data),
`ifdef RAM_PARITY_EN
        .perr_inject (perr_inject),
        .rd_perr     (rd_perr),
`endif
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .ready       (ready),
        .err         (err)
    );

    ram_sync_param #(.DEPTH(DEPTH_B)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .cs1         (cs1),
        .cs2         (cs2),
        .rd          (rd),
        .wr          (wr),
        .addr        (addr),
        .wr_data     (wr_data),
`ifdef RAM_PARITY_EN
        .perr_inject (perr_inject),
        .rd_perr     (b_rd_perr),
`endif
        .rd_data     (b_rd_data),
        .rd_valid    (b_rd_valid),
        .ready       (b_ready),
        .err         (b_err)
    );

    task automatic bus_idle();
        cs1 = 1'b0;
        cs2 = 1'b0;
        rd  = 1'b0;
        wr  = 1'b0;
`ifdef RAM_PARITY_EN
        perr_inject = 1'b0;
`endif
    endtask

    task automatic model_clear();
        foreach (model[i]) begin
            model[i]      = '0;
            model_perr[i] = 1'b0;
        end
        exp_q.delete();
    endtask

    // One bus cycle on the default instance, which is in IDLE here.
    task automatic req(input logic c1, input logic c2, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic inj,
                       input string name);
        logic sel, acc, exp_valid, exp_err;
        exp_t e;
        @(negedge clk);
        cs1 = c1; cs2 = c2; rd = r; wr = w; addr = a; wr_data = d;
`ifdef RAM_PARITY_EN
        perr_inject = inj;
`endif
        sel       = c1 & ~c2;
        acc       = sel & (r ^ w);
        exp_valid = acc & r;
        exp_err   = sel & r & w;
        if (exp_valid) exp_q.push_back('{data: model[a], perr: model_perr[a]});
        if (acc && w) begin
            model[a]      = d;
            model_perr[a] = inj;
        end
        @(posedge clk); #1;
        checks++;
        if (rd_valid !== exp_valid) begin
            errors++;
            $display("FAIL %s rd_valid got %b want %b", name, rd_valid, exp_valid);
        end
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL %s err got %b want %b", name, err, exp_err);
        end
        if (exp_valid) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_data !== e.data) begin
                errors++;
                $display("FAIL %s rd_data got %h want %h", name, rd_data, e.data);
            end
`ifdef RAM_PARITY_EN
            checks++;
            if (rd_perr !== e.perr) begin
                errors++;
                $display("FAIL %s rd_perr got %b want %b", name, rd_perr, e.perr);
            end
`endif
        end
        bus_idle();
    endtask

    // Releases reset and counts cycles until both instances report ready,
    // hammering a write to address 0 that the sweep must ignore.
    task automatic sweep(input string name);
        int n, na, nb;
        n = 0; na = 0; nb = 0;
        @(negedge clk);
        rst = 1'b0;
        cs1 = 1'b1; wr = 1'b1; addr = '0; wr_data = 8'hEE;
        while ((!ready || !b_ready) && n < 1000) begin
            @(posedge clk); #1;
            n++;
            if (ready && na == 0) na = n;
            if (b_ready && nb == 0) nb = n;
            if (n <= 3) begin
                checks++;
                if (rd_valid !== 1'b0 || err !== 1'b0) begin
                    errors++;
                    $display("FAIL %s bus during clear got valid=%b err=%b want 0 0", name, rd_valid, err);
                end
            end
            if (n == 3) bus_idle();
        end
        bus_idle();
        checks++;
        if (na != DEPTH_A) begin
            errors++;
            $display("FAIL %s clear cycles got %0d want %0d", name, na, DEPTH_A);
        end
        checks++;
        if (nb != DEPTH_B) begin
            errors++;
            $display("FAIL %s clear cycles depth100 got %0d want %0d", name, nb, DEPTH_B);
        end
        model_clear();
    endtask

    task automatic test_reset();
        bus_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rd_data !== 8'h00 || rd_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs got data=%h valid=%b err=%b want 00 0 0", rd_data, rd_valid, err);
        end
        checks++;
        if (ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset ready got %b/%b want 0/0", ready, b_ready);
        end
        sweep("reset_sweep");
        req(1, 0, 1, 0, 7'd0,   8'h00, 0, "rd_clear_0");
        req(1, 0, 1, 0, 7'd10,  8'h00, 0, "rd_clear_10");
        req(1, 0, 1, 0, 7'd127, 8'h00, 0, "rd_clear_127");
    endtask

    task automatic test_back_to_back();
        req(1, 0, 0, 1, 7'd10, 8'hAA, 0, "wr_10");
        req(1, 0, 0, 1, 7'd20, 8'hFF, 0, "wr_20");
        req(1, 0, 1, 0, 7'd10, 8'h00, 0, "b2b_rd_10");
        req(1, 0, 1, 0, 7'd20, 8'h00, 0, "b2b_rd_20");
        @(posedge clk); #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_hold got valid=%b data=%h want 0 ff", rd_valid, rd_data);
        end
        req(1, 0, 0, 1, 7'd30, 8'h5A, 0, "wr_30");
        req(1, 0, 1, 0, 7'd30, 8'h00, 0, "rd_after_wr_30");
    endtask

    task automatic test_deselect();
        req(1, 1, 0, 1, 7'd10, 8'h55, 0, "desel_cs2_wr");
        req(0, 0, 0, 1, 7'd10, 8'h55, 0, "desel_cs1_wr");
        req(0, 1, 1, 0, 7'd10, 8'h00, 0, "desel_rd");
        req(1, 0, 1, 0, 7'd10, 8'h00, 0, "resel_rd_10");
        checks++;
        if (rd_data !== 8'hAA) begin
            errors++;
            $display("FAIL resel_value got %h want aa", rd_data);
        end
    endtask

    task automatic test_conflict();
        req(1, 0, 1, 1, 7'd20, 8'h00, 0, "rdwr_conflict");
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL conflict_err_pulse got %b want 0", err);
        end
        req(1, 0, 1, 0, 7'd20, 8'h00, 0, "conflict_rd_20");
    endtask

    task automatic test_depth100();
        @(negedge clk);
        cs1 = 1'b1; wr = 1'b1; addr = 7'd100; wr_data = 8'h77;
        model[100] = 8'h77;
        model_perr[100] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (b_err !== 1'b1 || b_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL oor_wr got err=%b valid=%b want 1 0", b_err, b_rd_valid);
        end
        bus_idle();
        @(negedge clk);
        cs1 = 1'b1; rd = 1'b1; addr = 7'd100;
        @(posedge clk); #1;
        checks++;
        if (b_rd_valid !== 1'b1 || b_err !== 1'b1 || b_rd_data !== 8'h00) begin
            errors++;
            $display("FAIL oor_rd got valid=%b err=%b data=%h want 1 1 00", b_rd_valid, b_err, b_rd_data);
        end
`ifdef RAM_PARITY_EN
        checks++;
        if (b_rd_perr !== 1'b0) begin
            errors++;
            $display("FAIL oor_rd_perr got %b want 0", b_rd_perr);
        end
`endif
        bus_idle();
        @(negedge clk);
        cs1 = 1'b1; rd = 1'b1; addr = 7'd99;
        @(posedge clk); #1;
        checks++;
        if (b_rd_valid !== 1'b1 || b_err !== 1'b0 || b_rd_data !== 8'h00) begin
            errors++;
            $display("FAIL last_word_rd got valid=%b err=%b data=%h want 1 0 00", b_rd_valid, b_err, b_rd_data);
        end
        bus_idle();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        req(1, 0, 0, 1, 7'd10, 8'hC3, 0, "pre_rst_wr");
        @(negedge clk);
        cs1 = 1'b1; rd = 1'b1; addr = 7'd10;
        @(posedge clk); #1;
        bus_idle();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hC3) begin
            errors++;
            $display("FAIL mid_read got valid=%b data=%h want 1 c3", rd_valid, rd_data);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 || ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_read got valid=%b data=%h ready=%b want 0 00 0", rd_valid, rd_data, ready);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sweep("rst_mid_clear");
        req(1, 0, 1, 0, 7'd10, 8'h00, 0, "rerun_rd_10");
        req(1, 0, 1, 0, 7'd20, 8'h00, 0, "rerun_rd_20");
    endtask

`ifdef RAM_PARITY_EN
    task automatic test_parity();
        req(1, 0, 0, 1, 7'd5, 8'h3C, 1, "perr_inject_wr");
        req(1, 0, 1, 0, 7'd5, 8'h00, 0, "perr_rd_bad");
        req(1, 0, 0, 1, 7'd5, 8'h3C, 0, "perr_clean_wr");
        req(1, 0, 1, 0, 7'd5, 8'h00, 0, "perr_rd_good");
    endtask
`endif

    initial begin
        model_clear();
        test_reset();
        test_back_to_back();
        test_deselect();
        test_conflict();
        test_depth100();
`ifdef RAM_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
